int_mul_pipe: RTL
=================

Name: int_mul_pipe

Overview:
- Pipelined, handshaked integer multiplier functional unit for the stage3 execute cluster; successor to the combinational multiplier.
- Covers the full RV M-extension multiply set (MUL, MULH, MULHSU, MULHU), plus MULW as an optional feature.
- Splits operands into MUL_SIZE-bit chunks and accumulates partial products across STAGES registered stages.
- Supports backpressure, a result tag and pipeline flush on branch mispredict or trap.

Parameters:
- XLEN, 64, operand/result width; must be a multiple of MUL_SIZE.
- MUL_SIZE, 16, sub-multiplier chunk width.
- STAGES, 3, pipeline depth in cycles, 1..4; also the latency.
- TAG_W, 6, width of the ROB/destination tag carried alongside each operation.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit accepts the operation this cycle
- op  in  3  op[1:0] = funct3[1:0] (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU); op[2] = word (W) op
- a  in  XLEN  rs1 value
- b  in  XLEN  rs2 value
- tag  in  TAG_W  tag returned with the result
- flush  in  1  kill all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  selected product word
- out_tag  out  TAG_W  tag of the result

Behaviour:
- Reset values: out_valid=0, result=0, out_tag=0, every stage valid bit=0. in_ready=1 once rst deasserts. Reset is asynchronous and honoured mid-operation; all in-flight operations are lost.
- Handshake:
  - Accept on in_valid && in_ready.
  - Result transfers on out_valid && out_ready.
  - out_valid, result and out_tag stay stable while out_valid && !out_ready.
- Global stall: advance = !out_valid || out_ready; in_ready = advance.
  - On advance, every stage shifts one step; stage 0 loads the new op, or a bubble when nothing is accepted.
  - Bubbles are not compressed.
- Latency: exactly STAGES cycles from acceptance to out_valid with no stall. Throughput is 1 op/cycle.
- Operand extension to XLEN+1 bits:
  - a is signed for MULH and MULHSU.
  - b is signed for MULH only.
  - Otherwise operands are zero-extended.
- Product is the full 2*XLEN-bit two's complement result.
- Result select:
  - MUL: product[XLEN-1:0].
  - MULH/MULHSU/MULHU: product[2XLEN-1:XLEN].
- Partial products:
  - (XLEN/MUL_SIZE)^2 chunk products are formed in stage 0.
  - They are reduced across stages.
  - The final sign correction and select happen in the last stage.
  - The split across stages is left to the implementation; only latency and results are checked.
- Flush:
  - On flush=1, all stage valid bits and out_valid clear at the next edge.
  - An input offered in the same cycle is dropped, even if in_ready=1.
  - flush takes priority over advance.
  - out_valid is 0 in the cycle after flush.
- Simultaneous output transfer and input accept in a full pipeline is legal and sustains 1 op/cycle.
- Boundary values:
  - Overflow wraps silently.
  - MULH of -2^(XLEN-1) × -2^(XLEN-1) is 2^(XLEN-2) in the upper word.

Optional Feature:
- Macro INT_MUL_WORD_EN.
- Defined:
  - op[2]=1 (MULW, valid only with op[1:0]=00) multiplies a[31:0]×b[31:0].
  - result = sign-extension of product[31:0] to XLEN.
  - Latency is unchanged.
- Undefined:
  - op[2] is ignored and MULW executes as MUL.
  - No word datapath logic is generated.

Test Plan:
- Reset then single MUL, a=7, b=6, tag=3 -> out_valid exactly STAGES cycles later, result=42, out_tag=3.
- Signedness, all with a=-1 (all ones) and b=2:
  - MULH -> 0xFFFF_FFFF_FFFF_FFFF.
  - MULHU -> 0x0000_0000_0000_0001.
  - MULHSU -> 0xFFFF_FFFF_FFFF_FFFF.
  - MUL -> 0xFFFF_FFFF_FFFF_FFFE.
- Backpressure: stream 8 ops with tags 0..7 and out_ready low for 5 cycles mid-stream -> in_ready follows advance, result/out_tag held stable while stalled, all 8 results delivered in order with no loss or duplication.
- Flush: 3 ops in flight plus a 4th offered with flush=1 -> out_valid=0 the next cycle, none of the 4 results ever appear; the next op (a=3, b=5) returns 15.
- MULW with INT_MUL_WORD_EN, a=0x0000_0001_8000_0000, b=2 -> result=0x0000_0000_0000_0000; a=0x4000_0000, b=2 -> 0xFFFF_FFFF_8000_0000. Without the macro, same ops return MUL results.
- Async reset asserted while 2 ops are in flight -> out_valid=0 immediately without a clock edge, and no result emerges after release.

Source files
------------

// File: rtl/int_mul_pipe.sv
// int_mul_pipe: pipelined, handshaked RV64 M-extension multiplier
// (MUL, MULH, MULHSU, MULHU), latency STAGES cycles, 1 op/cycle.
// Optional feature macro: INT_MUL_WORD_EN adds MULW (op[2]=1).
// Operands are split into MUL_SIZE-bit chunks; all chunk products are formed
// in stage 0, row accumulators are tree-reduced in the middle stages, and the
// signed-operand correction plus result select happen in the last stage.
// XLEN must be a multiple of MUL_SIZE (and >= 32 when MULW is enabled).
module int_mul_pipe #(
  parameter int XLEN     = 64,
  parameter int MUL_SIZE = 16,
  parameter int STAGES   = 3,
  parameter int TAG_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [TAG_W-1:0] tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = XLEN / MUL_SIZE;
  localparam int W2 = 2 * XLEN;

  // One in-flight operation: N row accumulators whose sum is the unsigned
  // product, plus the upper-word correction for signed operands.
  typedef struct packed {
    logic [N-1:0][W2-1:0] acc;
    logic [XLEN-1:0]      corr;
    logic                 hi;
`ifdef INT_MUL_WORD_EN
    logic                 word;
`endif
    logic [TAG_W-1:0]     tag;
  } pay_t;

  // Pairwise add with the given stride; consumed entries are zeroed so the
  // sum over all accumulators is preserved at every step.
  function automatic pay_t reduce(input pay_t p, input int stride);
    pay_t r;
    int   k;
    r = p;
    for (int j = 0; j < N; j++) begin
      k = j + stride;
      if ((j % (2 * stride)) == 0 && k < N) r.acc[j] = p.acc[j] + p.acc[k];
      else if ((j % (2 * stride)) == stride) r.acc[j] = '0;
    end
    return r;
  endfunction

  logic                  advance, accept;
  logic [STAGES-1:0]     vld_q, vld_d;
  logic [XLEN-1:0]       result_q, res_d;
  logic [TAG_W-1:0]      tag_q;
  pay_t                  pin, pend;
  logic                  sa, sb;
  logic [XLEN-1:0]       au, bu;
  logic [2*MUL_SIZE-1:0] pp;
  logic [W2-1:0]         sum;

  // Global stall: everything moves only when the output slot can drain.
  assign advance   = !vld_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance && !flush;
  assign out_valid = vld_q[STAGES-1];
  assign result    = result_q;
  assign out_tag   = tag_q;

`ifndef INT_MUL_WORD_EN
  logic unused_op2;
  assign unused_op2 = op[2];
`endif

  // Stage 0: operand extension, sign correction term and all chunk products.
  always_comb begin
    pin = '0;
    au  = a;
    bu  = b;
    pp  = '0;
    sa  = a[XLEN-1] & (op[1:0] == 2'b01 || op[1:0] == 2'b10);
    sb  = b[XLEN-1] & (op[1:0] == 2'b01);
`ifdef INT_MUL_WORD_EN
    if (op[2]) begin
      au = {{(XLEN-32){1'b0}}, a[31:0]};
      bu = {{(XLEN-32){1'b0}}, b[31:0]};
      sa = 1'b0;
      sb = 1'b0;
    end
    pin.word = op[2];
`endif
    // A signed operand x equals xu - 2^XLEN*sign, so the product needs
    // -(sa*bu + sb*au) added into the upper word (mod 2^(2*XLEN)).
    pin.corr = '0 - ((sa ? bu : '0) + (sb ? au : '0));
    pin.hi   = (op[1:0] != 2'b00);
    pin.tag  = tag;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp = {{MUL_SIZE{1'b0}}, au[i*MUL_SIZE +: MUL_SIZE]} *
             {{MUL_SIZE{1'b0}}, bu[j*MUL_SIZE +: MUL_SIZE]};
        pin.acc[j] = pin.acc[j] + ({{(W2-2*MUL_SIZE){1'b0}}, pp} << ((i + j) * MUL_SIZE));
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_direct
      assign pend = pin;
    end else begin : g_pipe
      pay_t pipe_q [STAGES-1];
      // Payload shift with tree reduction between stages; bubbles carry
      // don't-care data, qualified by the valid bits.
      always_ff @(posedge clk) begin
        if (advance) begin
          pipe_q[0] <= pin;
          for (int s = 1; s < STAGES - 1; s++) pipe_q[s] <= reduce(pipe_q[s-1], 1 << (s - 1));
        end
      end
      assign pend = pipe_q[STAGES-2];
    end
  endgenerate

  // Last stage: final accumulation, sign correction and word select.
  always_comb begin
    sum = {pend.corr, {XLEN{1'b0}}};
    for (int j = 0; j < N; j++) sum = sum + pend.acc[j];
    res_d = pend.hi ? sum[W2-1:XLEN] : sum[XLEN-1:0];
`ifdef INT_MUL_WORD_EN
    if (pend.word) res_d = {{(XLEN-32){sum[31]}}, sum[31:0]};
`endif
  end

  // Valid shift register input: new op (or bubble) enters at stage 0.
  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int s = 1; s < STAGES; s++) vld_d[s] = vld_q[s-1];
  end

  // Valid bits and output register; flush kills everything, beats advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else if (flush) begin
      vld_q <= '0;
    end else if (advance) begin
      vld_q <= vld_d;
      if (vld_d[STAGES-1]) begin
        result_q <= res_d;
        tag_q    <= pend.tag;
      end
    end
  end

endmodule
